// File: rtl/tlc_rightofway_sched.sv
// Right-of-way scheduler: farm/ped/emergency arbitration for the shared green phase.
// Latency: outputs are registered and change on the edge after the deciding input is sampled.
// Backpressure: none. Requests latch until served; TLC_GAP_EXTEND_EN enables farm-green gap extension.
module tlc_rightofway_sched #(
  parameter int TW        = 8,
  parameter int H_MIN_G   = 20,
  parameter int Y_TIME    = 6,
  parameter int AR_TIME   = 2,
  parameter int F_GREEN   = 20,
`ifdef TLC_GAP_EXTEND_EN
  parameter int F_EXT     = 10,
`endif
  parameter int WALK_TIME = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       farmSensor,
  input  logic       ped_btn,
  input  logic       emerg,
  output logic [1:0] h_s,
  output logic [1:0] f_s,
  output logic       walk,
  output logic       emerg_ack,
  output logic [2:0] state,
  output logic       farm_pend,
  output logic       ped_pend
);

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    FG  = 3'd3,
    FY  = 3'd4,
    AR2 = 3'd5
  } phase_t;

  localparam logic [TW-1:0] H_LAST   = TW'(H_MIN_G - 1);
  localparam logic [TW-1:0] Y_LAST   = TW'(Y_TIME - 1);
  localparam logic [TW-1:0] AR_LAST  = TW'(AR_TIME - 1);
  localparam logic [TW-1:0] F_LAST   = TW'(F_GREEN - 1);
  localparam logic [TW-1:0] WALK_END = TW'(WALK_TIME);
  localparam logic [TW-1:0] T_MAX    = {TW{1'b1}};
`ifdef TLC_GAP_EXTEND_EN
  localparam logic [TW-1:0] X_LAST   = TW'(F_GREEN + F_EXT - 1);
`endif

  phase_t        cur, nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          farm_nxt, ped_nxt;
  logic          walk_flag, walk_flag_nxt;
  logic          fg_entry, fg_exit;

  function automatic logic [1:0] lamp_h(input phase_t p);
    case (p)
      HG:      lamp_h = 2'b10;
      HY:      lamp_h = 2'b01;
      default: lamp_h = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] lamp_f(input phase_t p);
    case (p)
      FG:      lamp_f = 2'b10;
      FY:      lamp_f = 2'b01;
      default: lamp_f = 2'b00;
    endcase
  endfunction

  always_comb begin
    nxt = cur;
    case (cur)
      HG:  if (timer >= H_LAST && (farm_pend || ped_pend) && !emerg) nxt = HY;
      HY:  if (timer == Y_LAST) nxt = AR1;
      AR1: if (timer == AR_LAST) nxt = emerg ? HG : FG;
      FG: begin
`ifdef TLC_GAP_EXTEND_EN
        // Hold green while vehicles keep arriving, capped at F_GREEN+F_EXT.
        if (emerg || (timer >= F_LAST && !farmSensor) || timer == X_LAST) nxt = FY;
`else
        if (emerg || timer == F_LAST) nxt = FY;
`endif
      end
      FY:  if (timer == Y_LAST) nxt = AR2;
      AR2: if (timer == AR_LAST) nxt = HG;
      default: nxt = HG;
    endcase
  end

  always_comb begin
    fg_entry  = (nxt == FG) && (cur != FG);
    fg_exit   = (cur == FG) && (nxt != FG);
    timer_nxt = (nxt != cur) ? '0 : ((timer == T_MAX) ? timer : timer + TW'(1));

    // FG entry clear beats any same-cycle set; an emergency cut re-arms the farm request.
    if (fg_entry)                farm_nxt = 1'b0;
    else if (cur == FG && emerg) farm_nxt = 1'b1;
    else                         farm_nxt = farm_pend | (farmSensor && cur != FG);

    ped_nxt = fg_entry ? 1'b0 : (ped_pend | (ped_btn && !walk));

    if (fg_entry)     walk_flag_nxt = ped_pend;
    else if (fg_exit) walk_flag_nxt = 1'b0;
    else              walk_flag_nxt = walk_flag;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= HG;
      timer     <= '0;
      farm_pend <= 1'b0;
      ped_pend  <= 1'b0;
      walk_flag <= 1'b0;
      h_s       <= 2'b10;
      f_s       <= 2'b00;
      walk      <= 1'b0;
      emerg_ack <= 1'b0;
    end else begin
      cur       <= nxt;
      timer     <= timer_nxt;
      farm_pend <= farm_nxt;
      ped_pend  <= ped_nxt;
      walk_flag <= walk_flag_nxt;
      h_s       <= lamp_h(nxt);
      f_s       <= lamp_f(nxt);
      walk      <= (nxt == FG) && walk_flag_nxt && (timer_nxt < WALK_END);
      emerg_ack <= (nxt == HG) && emerg;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_tlc_rightofway_sched.sv
// Bench for tlc_rightofway_sched: directed checkpoint tables plus randomized traffic vs a phase-level model.
module tb_tlc_rightofway_sched;
  localparam int TW = 8, H_MIN_G = 20, Y_TIME = 6, AR_TIME = 2, F_GREEN = 20, WALK_TIME = 10;
`ifdef TLC_GAP_EXTEND_EN
  localparam int F_EXT = 10;
`endif

  logic clk = 1'b0, rst = 1'b1, farmSensor = 1'b0, ped_btn = 1'b0, emerg = 1'b0;
  logic [1:0] h_s, f_s;
  logic       walk, emerg_ack, farm_pend, ped_pend;
  logic [2:0] state;

  always #5 clk = ~clk;

  tlc_rightofway_sched #(.TW(TW), .H_MIN_G(H_MIN_G), .Y_TIME(Y_TIME), .AR_TIME(AR_TIME),
                         .F_GREEN(F_GREEN), .WALK_TIME(WALK_TIME)) dut (
    .clk(clk), .rst(rst), .farmSensor(farmSensor), .ped_btn(ped_btn), .emerg(emerg),
    .h_s(h_s), .f_s(f_s), .walk(walk), .emerg_ack(emerg_ack), .state(state),
    .farm_pend(farm_pend), .ped_pend(ped_pend));

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Phase-level reference model: phase index, elapsed cycles in phase, pending requests.
  int m_p, m_cnt;
  bit m_fp, m_pp, m_flag, m_ack;

  function automatic int dur(input int p);
    case (p)
      0: return H_MIN_G;
      1, 4: return Y_TIME;
      3: return F_GREEN;
      default: return AR_TIME;
    endcase
  endfunction

  function automatic int m_h(input int p);
    return (p == 0) ? 2 : (p == 1) ? 1 : 0;
  endfunction

  function automatic int m_f(input int p);
    return (p == 3) ? 2 : (p == 4) ? 1 : 0;
  endfunction

  function automatic bit m_walk();
    return (m_p == 3) && m_flag && (m_cnt < WALK_TIME);
  endfunction

  task automatic model_reset();
    m_p = 0; m_cnt = 0; m_fp = 0; m_pp = 0; m_flag = 0; m_ack = 0;
  endtask

  task automatic model_step(input bit fin, input bit pin, input bit ein);
    int  np;
    bit  done, fg_done, in_walk;
    np   = m_p;
    done = (m_cnt >= dur(m_p) - 1);
`ifdef TLC_GAP_EXTEND_EN
    fg_done = (m_cnt >= F_GREEN - 1 && !fin) || (m_cnt >= F_GREEN + F_EXT - 1);
`else
    fg_done = done;
`endif
    case (m_p)
      0: if (done && (m_fp || m_pp) && !ein) np = 1;
      2: if (done) np = ein ? 0 : 3;
      3: if (ein || fg_done) np = 4;
      default: if (done) np = (m_p + 1) % 6;
    endcase
    in_walk = m_walk();
    if (np == 3 && m_p != 3) begin
      m_flag = m_pp; m_fp = 0; m_pp = 0;
    end else begin
      if (m_p == 3 && ein) m_fp = 1;
      else if (fin && m_p != 3) m_fp = 1;
      if (pin && !in_walk) m_pp = 1;
    end
    if (m_p == 3 && np != 3) m_flag = 0;
    m_cnt = (np != m_p) ? 0 : ((m_cnt < 2**TW - 1) ? m_cnt + 1 : m_cnt);
    m_ack = (np == 0) && ein;
    m_p   = np;
  endtask

  task automatic check_model(input string tag, input int c);
    chk($sformatf("%s c%0d state", tag, c), int'(state), m_p);
    chk($sformatf("%s c%0d h_s", tag, c), int'(h_s), m_h(m_p));
    chk($sformatf("%s c%0d f_s", tag, c), int'(f_s), m_f(m_p));
    chk($sformatf("%s c%0d walk", tag, c), int'(walk), int'(m_walk()));
    chk($sformatf("%s c%0d emerg_ack", tag, c), int'(emerg_ack), int'(m_ack));
    chk($sformatf("%s c%0d farm_pend", tag, c), int'(farm_pend), int'(m_fp));
    chk($sformatf("%s c%0d ped_pend", tag, c), int'(ped_pend), int'(m_pp));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " state"}, int'(state), 0);
    chk({tag, " h_s"}, int'(h_s), 2);
    chk({tag, " f_s"}, int'(f_s), 0);
    chk({tag, " walk"}, int'(walk), 0);
    chk({tag, " emerg_ack"}, int'(emerg_ack), 0);
    chk({tag, " farm_pend"}, int'(farm_pend), 0);
    chk({tag, " ped_pend"}, int'(ped_pend), 0);
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b0; farmSensor = 1'b0; ped_btn = 1'b0; emerg = 1'b0;
    #2;
    check_reset_vals("reset");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic tick();
    model_step(farmSensor, ped_btn, emerg);
    @(posedge clk); #1;
  endtask

  typedef struct {
    int farm_a, farm_b, ped_a, ped_b, ped_c, e_on, e_off, len;
  } scen_t;

  typedef struct {
    int sc, cyc, st, h, f, wk, fp, pp, ack;
  } cp_t;

  scen_t scen[5];
  cp_t   cps[$];

  task automatic add_cp(input int sc, cyc, st, h, f, wk, fp, pp, ack);
    cp_t r;
    r.sc = sc; r.cyc = cyc; r.st = st; r.h = h; r.f = f;
    r.wk = wk; r.fp = fp; r.pp = pp; r.ack = ack;
    cps.push_back(r);
  endtask

  initial begin
    // combined request, walk window, ped ignored during walk then accepted after
    scen[0] = '{5, -1, 5, 30, 40, -1, -1, 60};
    // single farm pulse: min green then full farm cycle
    scen[1] = '{5, -1, -1, -1, -1, -1, -1, 60};
    // emergency during farm green
    scen[2] = '{5, -1, -1, -1, -1, 33, 50, 65};
    // long idle then late request
    scen[3] = '{200, -1, -1, -1, -1, -1, -1, 235};
    // reach yellow with both latches set, then async reset
    scen[4] = '{5, 49, 40, -1, -1, -1, -1, 50};

    //      sc cyc st h  f  wk fp pp ack
    add_cp(0,  0, 0, 2, 0, 0, 0, 0, 0);
    add_cp(0,  6, 0, 2, 0, 0, 1, 1, 0);
    add_cp(0, 28, 3, 0, 2, 1, 0, 0, 0);
    add_cp(0, 31, 3, 0, 2, 1, 0, 0, 0);
    add_cp(0, 37, 3, 0, 2, 1, 0, 0, 0);
    add_cp(0, 38, 3, 0, 2, 0, 0, 0, 0);
    add_cp(0, 41, 3, 0, 2, 0, 0, 1, 0);
    add_cp(0, 47, 3, 0, 2, 0, 0, 1, 0);
    add_cp(0, 48, 4, 0, 1, 0, 0, 1, 0);
    add_cp(1,  5, 0, 2, 0, 0, 0, 0, 0);
    add_cp(1,  6, 0, 2, 0, 0, 1, 0, 0);
    add_cp(1, 19, 0, 2, 0, 0, 1, 0, 0);
    add_cp(1, 20, 1, 1, 0, 0, 1, 0, 0);
    add_cp(1, 25, 1, 1, 0, 0, 1, 0, 0);
    add_cp(1, 26, 2, 0, 0, 0, 1, 0, 0);
    add_cp(1, 27, 2, 0, 0, 0, 1, 0, 0);
    add_cp(1, 28, 3, 0, 2, 0, 0, 0, 0);
    add_cp(1, 47, 3, 0, 2, 0, 0, 0, 0);
    add_cp(1, 48, 4, 0, 1, 0, 0, 0, 0);
    add_cp(1, 54, 5, 0, 0, 0, 0, 0, 0);
    add_cp(1, 56, 0, 2, 0, 0, 0, 0, 0);
    add_cp(1, 60, 0, 2, 0, 0, 0, 0, 0);
    add_cp(2, 33, 3, 0, 2, 0, 0, 0, 0);
    add_cp(2, 34, 4, 0, 1, 0, 1, 0, 0);
    add_cp(2, 39, 4, 0, 1, 0, 1, 0, 0);
    add_cp(2, 40, 5, 0, 0, 0, 1, 0, 0);
    add_cp(2, 41, 5, 0, 0, 0, 1, 0, 0);
    add_cp(2, 42, 0, 2, 0, 0, 1, 0, 1);
    add_cp(2, 50, 0, 2, 0, 0, 1, 0, 1);
    add_cp(2, 51, 0, 2, 0, 0, 1, 0, 0);
    add_cp(2, 61, 0, 2, 0, 0, 1, 0, 0);
    add_cp(2, 62, 1, 1, 0, 0, 1, 0, 0);
    add_cp(3,199, 0, 2, 0, 0, 0, 0, 0);
    add_cp(3,201, 0, 2, 0, 0, 1, 0, 0);
    add_cp(3,202, 1, 1, 0, 0, 1, 0, 0);
    add_cp(3,209, 2, 0, 0, 0, 1, 0, 0);
    add_cp(3,210, 3, 0, 2, 0, 0, 0, 0);
    add_cp(3,229, 3, 0, 2, 0, 0, 0, 0);
    add_cp(3,230, 4, 0, 1, 0, 0, 0, 0);
    add_cp(4, 50, 4, 0, 1, 0, 1, 1, 0);

    for (int s = 0; s < 5; s++) begin
      do_reset();
      for (int c = 0; c <= scen[s].len; c++) begin
        foreach (cps[k]) begin
          if (cps[k].sc == s && cps[k].cyc == c) begin
            chk($sformatf("s%0d c%0d state", s, c), int'(state), cps[k].st);
            chk($sformatf("s%0d c%0d h_s", s, c), int'(h_s), cps[k].h);
            chk($sformatf("s%0d c%0d f_s", s, c), int'(f_s), cps[k].f);
            chk($sformatf("s%0d c%0d walk", s, c), int'(walk), cps[k].wk);
            chk($sformatf("s%0d c%0d farm_pend", s, c), int'(farm_pend), cps[k].fp);
            chk($sformatf("s%0d c%0d ped_pend", s, c), int'(ped_pend), cps[k].pp);
            chk($sformatf("s%0d c%0d emerg_ack", s, c), int'(emerg_ack), cps[k].ack);
          end
        end
        check_model($sformatf("s%0d", s), c);
        if (c < scen[s].len) begin
          farmSensor = (c == scen[s].farm_a) || (c == scen[s].farm_b);
          ped_btn    = (c == scen[s].ped_a) || (c == scen[s].ped_b) || (c == scen[s].ped_c);
          emerg      = (c >= scen[s].e_on) && (c < scen[s].e_off);
          tick();
        end
      end
      if (s == 4) begin
        // Reset between edges must take effect without a clock.
        #3;
        rst = 1'b0;
        #1;
        check_reset_vals("async reset in FY");
      end
    end

    begin
      int e_left;
      e_left = 0;
      do_reset();
      for (int c = 0; c < 4000; c++) begin
        farmSensor = ($urandom % 20) == 0;
        ped_btn    = ($urandom % 30) == 0;
        if (e_left > 0) begin
          emerg = 1'b1;
          e_left--;
        end else begin
          emerg = 1'b0;
          if ($urandom % 150 == 0) e_left = $urandom_range(1, 40);
        end
        tick();
        check_model("rand", c);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
